// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with register file, branch resolution, hazard detection and ID/EX register; optional FORWARDING_EN enables EX/MEM operand forwarding
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int REG_CNT     = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [31:0]            i_inst,
    input  logic [XLEN-1:0]        i_pc,
    output logic                   o_ready,
    input  logic                   i_ex_ready,
    input  logic                   i_flush,
    input  logic                   i_wb_en,
    input  logic [4:0]             i_wb_rd_num,
    input  logic [XLEN-1:0]        i_wb_val,
    input  logic [XLEN-1:0]        i_ex_fwd_val,
    input  logic                   i_mem_wr_en,
    input  logic [4:0]             i_mem_rd_num,
    input  logic [XLEN-1:0]        i_mem_fwd_val,
    output logic                   o_valid,
    output logic [XLEN-1:0]        o_pc,
    output logic [XLEN-1:0]        o_rs_1,
    output logic [XLEN-1:0]        o_rs_2,
    output logic [XLEN-1:0]        o_imm,
    output logic [4:0]             o_rd_num,
    output logic [6:0]             o_opcode,
    output logic [2:0]             o_func_3,
    output logic [6:0]             o_func_7,
    output logic                   o_illegal,
    output logic                   o_b_taken,
    output logic [XLEN-1:0]        o_b_pc,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam int              RIDX_W    = $clog2(REG_CNT);
    localparam logic [5:0]      REG_LIM   = 6'(REG_CNT);
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] rf [REG_CNT];

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = i_inst[6:0];
    assign rd     = i_inst[11:7];
    assign f3     = i_inst[14:12];
    assign rs1    = i_inst[19:15];
    assign rs2    = i_inst[24:20];
    assign f7     = i_inst[31:25];

    logic               known;
    logic               use_rs1;
    logic               use_rs2;
    logic               writes_rd;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm_ext;
    logic               bad_idx;
    logic               illegal;
    logic [4:0]         dec_rd;

    // Classify the opcode: which sources it reads, whether it writes rd, and its immediate format
    always_comb begin
        known     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        imm32     = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
                imm32     = {i_inst[31:12], 12'b0};
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                imm32     = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                             i_inst[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                writes_rd = 1'b1;
                use_rs1   = 1'b1;
                imm32     = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                           i_inst[11:8], 1'b0};
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            OP_OP: begin
                writes_rd = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    // A signed 32-bit immediate widens to XLEN with sign extension from inst[31]
    assign imm_ext = XLEN'(imm32);

    assign bad_idx = (use_rs1   && ({1'b0, rs1} >= REG_LIM)) ||
                     (use_rs2   && ({1'b0, rs2} >= REG_LIM)) ||
                     (writes_rd && ({1'b0, rd}  >= REG_LIM));
    assign illegal = !known || bad_idx;
    assign dec_rd  = (writes_rd && !illegal) ? rd : 5'd0;

    logic [XLEN-1:0] rf_1;
    logic [XLEN-1:0] rf_2;

    // Register-file read port 1 with x0 hardwired to zero and same-cycle WB bypass
    always_comb begin
        rf_1 = '0;
        if (rs1 == 5'd0 || {1'b0, rs1} >= REG_LIM) begin
            rf_1 = '0;
        end else if (i_wb_en && i_wb_rd_num == rs1) begin
            rf_1 = i_wb_val;
        end else begin
            rf_1 = rf[rs1[RIDX_W-1:0]];
        end
    end

    // Register-file read port 2 with x0 hardwired to zero and same-cycle WB bypass
    always_comb begin
        rf_2 = '0;
        if (rs2 == 5'd0 || {1'b0, rs2} >= REG_LIM) begin
            rf_2 = '0;
        end else if (i_wb_en && i_wb_rd_num == rs2) begin
            rf_2 = i_wb_val;
        end else begin
            rf_2 = rf[rs2[RIDX_W-1:0]];
        end
    end

    // o_rd_num is zero for non-writing entries, so a nonzero match implies a real producer
    logic ex_hit_1;
    logic ex_hit_2;
    logic mem_hit_1;
    logic mem_hit_2;

    assign ex_hit_1  = use_rs1 && o_valid && (o_rd_num != 5'd0) && (o_rd_num == rs1);
    assign ex_hit_2  = use_rs2 && o_valid && (o_rd_num != 5'd0) && (o_rd_num == rs2);
    assign mem_hit_1 = use_rs1 && i_mem_wr_en && (i_mem_rd_num != 5'd0) && (i_mem_rd_num == rs1);
    assign mem_hit_2 = use_rs2 && i_mem_wr_en && (i_mem_rd_num != 5'd0) && (i_mem_rd_num == rs2);

    logic [XLEN-1:0] op_1;
    logic [XLEN-1:0] op_2;
    logic            raw_hazard;

`ifdef FORWARDING_EN
    // EX beats MEM beats the register file; only a load in EX cannot be forwarded yet
    always_comb begin
        op_1       = ex_hit_1 ? i_ex_fwd_val : (mem_hit_1 ? i_mem_fwd_val : rf_1);
        op_2       = ex_hit_2 ? i_ex_fwd_val : (mem_hit_2 ? i_mem_fwd_val : rf_2);
        raw_hazard = (o_opcode == OP_LOAD) && (ex_hit_1 || ex_hit_2);
    end
`else
    // Without forwarding, any in-flight producer in EX or MEM stalls until it reaches WB
    always_comb begin
        op_1       = rf_1;
        op_2       = rf_2;
        raw_hazard = ex_hit_1 || ex_hit_2 || mem_hit_1 || mem_hit_2;
    end

    logic unused_fwd;
    assign unused_fwd = ^{i_ex_fwd_val, i_mem_fwd_val};
`endif

    logic            cond;
    logic            taken;
    logic [XLEN-1:0] target;

    // Resolve branch condition and redirect target from the selected operands
    always_comb begin
        cond = 1'b0;
        case (f3)
            3'b000:  cond = (op_1 == op_2);
            3'b001:  cond = (op_1 != op_2);
            3'b100:  cond = ($signed(op_1) <  $signed(op_2));
            3'b101:  cond = ($signed(op_1) >= $signed(op_2));
            3'b110:  cond = (op_1 <  op_2);
            3'b111:  cond = (op_1 >= op_2);
            default: cond = 1'b0;
        endcase
        taken  = !illegal && (((opcode == OP_BRANCH) && cond) ||
                              (opcode == OP_JAL) || (opcode == OP_JALR));
        target = (opcode == OP_JALR) ? ((op_1 + imm_ext) & JALR_MASK) : (i_pc + imm_ext);
    end

    logic squash;
    logic hazard;
    logic accept;

    // The cycle carrying the redirect pulse sees a wrong-path fetch, so nothing is taken in
    always_comb begin
        squash  = o_b_taken;
        hazard  = i_valid && !squash && raw_hazard;
        o_ready = !i_rst && !hazard && i_ex_ready && !i_flush && !squash;
        accept  = i_valid && o_ready;
    end

    // Register file write port; x0 and out-of-range indices are never written
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                rf[i] <= '0;
            end
        end else if (i_wb_en && i_wb_rd_num != 5'd0 && {1'b0, i_wb_rd_num} < REG_LIM) begin
            rf[i_wb_rd_num[RIDX_W-1:0]] <= i_wb_val;
        end
    end

    // ID/EX register: flush, then hold on backpressure, then stall bubble, then load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_pc        <= '0;
            o_rs_1      <= '0;
            o_rs_2      <= '0;
            o_imm       <= '0;
            o_rd_num    <= '0;
            o_opcode    <= '0;
            o_func_3    <= '0;
            o_func_7    <= '0;
            o_illegal   <= 1'b0;
            o_stall_cnt <= '0;
        end else if (i_flush) begin
            o_valid   <= 1'b0;
            o_rd_num  <= '0;
            o_illegal <= 1'b0;
        end else if (!i_ex_ready) begin
            o_valid <= o_valid;
        end else if (hazard) begin
            o_valid   <= 1'b0;
            o_rd_num  <= '0;
            o_illegal <= 1'b0;
            if (o_stall_cnt != '1) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
        end else if (accept) begin
            o_valid   <= 1'b1;
            o_pc      <= i_pc;
            o_rs_1    <= op_1;
            o_rs_2    <= op_2;
            o_imm     <= imm_ext;
            o_rd_num  <= dec_rd;
            o_opcode  <= opcode;
            o_func_3  <= f3;
            o_func_7  <= f7;
            o_illegal <= illegal;
        end else begin
            o_valid   <= 1'b0;
            o_rd_num  <= '0;
            o_illegal <= 1'b0;
        end
    end

    // Redirect pulse: raised only by accepting a taken branch/jump, so it lasts one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_b_taken <= 1'b0;
            o_b_pc    <= '0;
        end else begin
            o_b_taken <= accept && taken;
            if (accept && taken) begin
                o_b_pc <= target;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_ex_ready, i_flush, i_wb_en, i_mem_wr_en;
    logic [31:0] i_inst, i_pc, i_wb_val, i_ex_fwd_val, i_mem_fwd_val;
    logic [4:0]  i_wb_rd_num, i_mem_rd_num;

    logic        o_ready, o_valid, o_illegal, o_b_taken;
    logic [31:0] o_pc, o_rs_1, o_rs_2, o_imm, o_b_pc;
    logic [4:0]  o_rd_num;
    logic [6:0]  o_opcode, o_func_7;
    logic [2:0]  o_func_3;
    logic [15:0] o_stall_cnt;

    logic        e_ready, e_valid, e_illegal, e_b_taken;
    logic [31:0] e_pc, e_rs_1, e_rs_2, e_imm, e_b_pc;
    logic [4:0]  e_rd_num;
    logic [6:0]  e_opcode, e_func_7;
    logic [2:0]  e_func_3;
    logic [15:0] e_stall_cnt;

    int total = 0;
    int bad   = 0;

`ifdef FORWARDING_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 2;
`endif

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .REG_CNT(32), .STALL_CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
        .o_ready(o_ready), .i_ex_ready(i_ex_ready), .i_flush(i_flush),
        .i_wb_en(i_wb_en), .i_wb_rd_num(i_wb_rd_num), .i_wb_val(i_wb_val),
        .i_ex_fwd_val(i_ex_fwd_val), .i_mem_wr_en(i_mem_wr_en),
        .i_mem_rd_num(i_mem_rd_num), .i_mem_fwd_val(i_mem_fwd_val),
        .o_valid(o_valid), .o_pc(o_pc), .o_rs_1(o_rs_1), .o_rs_2(o_rs_2), .o_imm(o_imm),
        .o_rd_num(o_rd_num), .o_opcode(o_opcode), .o_func_3(o_func_3), .o_func_7(o_func_7),
        .o_illegal(o_illegal), .o_b_taken(o_b_taken), .o_b_pc(o_b_pc),
        .o_stall_cnt(o_stall_cnt)
    );

    decode_stage #(.XLEN(32), .REG_CNT(16), .STALL_CNT_W(16)) u_dut_e (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
        .o_ready(e_ready), .i_ex_ready(i_ex_ready), .i_flush(i_flush),
        .i_wb_en(i_wb_en), .i_wb_rd_num(i_wb_rd_num), .i_wb_val(i_wb_val),
        .i_ex_fwd_val(i_ex_fwd_val), .i_mem_wr_en(i_mem_wr_en),
        .i_mem_rd_num(i_mem_rd_num), .i_mem_fwd_val(i_mem_fwd_val),
        .o_valid(e_valid), .o_pc(e_pc), .o_rs_1(e_rs_1), .o_rs_2(e_rs_2), .o_imm(e_imm),
        .o_rd_num(e_rd_num), .o_opcode(e_opcode), .o_func_3(e_func_3), .o_func_7(e_func_7),
        .o_illegal(e_illegal), .o_b_taken(e_b_taken), .o_b_pc(e_b_pc),
        .o_stall_cnt(e_stall_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        i_valid = 1'b1;
        i_inst  = inst;
        i_pc    = pc;
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b1; i_inst = 32'h0000_0013; i_pc = '0;
        i_ex_ready = 1'b1; i_flush = 1'b0; i_wb_en = 1'b0; i_wb_rd_num = '0; i_wb_val = '0;
        i_ex_fwd_val = 32'h5555_5555; i_mem_wr_en = 1'b0; i_mem_rd_num = '0;
        i_mem_fwd_val = '0;
        tick; tick;
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_rd", o_rd_num, 0);
        check("rst_pc", o_pc, 0);
        check("rst_btaken", o_b_taken, 0);
        check("rst_stall", o_stall_cnt, 0);
        i_rst = 1'b0; i_valid = 1'b0;

        // WB write x5 = 0x1234, then addi x6,x5,-1
        i_wb_en = 1'b1; i_wb_rd_num = 5'd5; i_wb_val = 32'h1234;
        tick;
        i_wb_en = 1'b0;
        present(32'hFFF2_8313, 32'h40);
        #1 check("addi_ready", o_ready, 1);
        tick;
        check("addi_valid", o_valid, 1);
        check("addi_rs1", o_rs_1, 32'h1234);
        check("addi_imm", o_imm, 32'hFFFF_FFFF);
        check("addi_rd", o_rd_num, 6);
        check("addi_pc", o_pc, 32'h40);
        check("addi_op", o_opcode, 7'h13);

        // lw x7,0(x1) then add x8,x7,x7 (load-use)
        present(32'h0000_A383, 32'h44);
        tick;
        check("lw_rd", o_rd_num, 7);
        check("lw_op", o_opcode, 7'h03);
        present(32'h0073_8433, 32'h48);
        i_mem_wr_en = 1'b1; i_mem_rd_num = 5'd6;
        #1 check("lu_ready0", o_ready, 0);
        tick;
        check("lu_bubble1", o_valid, 0);
        check("lu_stall1", o_stall_cnt, 1);
        i_mem_rd_num = 5'd7; i_mem_fwd_val = 32'hDEAD;
`ifdef FORWARDING_EN
        #1 check("lu_ready1", o_ready, 1);
        tick;
        check("lu_valid", o_valid, 1);
        check("lu_rs1", o_rs_1, 32'hDEAD);
        check("lu_rs2", o_rs_2, 32'hDEAD);
        check("lu_rd", o_rd_num, 8);
        i_mem_wr_en = 1'b0; i_valid = 1'b0;
        i_wb_en = 1'b1; i_wb_rd_num = 5'd7; i_wb_val = 32'hBEEF;
        tick;
`else
        #1 check("lu_ready1", o_ready, 0);
        tick;
        check("lu_bubble2", o_valid, 0);
        check("lu_stall2", o_stall_cnt, 2);
        i_mem_wr_en = 1'b0;
        i_wb_en = 1'b1; i_wb_rd_num = 5'd7; i_wb_val = 32'hBEEF;
        #1 check("lu_ready2", o_ready, 1);
        tick;
        check("lu_valid", o_valid, 1);
        check("lu_rs1", o_rs_1, 32'hBEEF);
        check("lu_rs2", o_rs_2, 32'hBEEF);
        check("lu_rd", o_rd_num, 8);
`endif
        i_wb_en = 1'b0; i_valid = 1'b0;
        tick;
        check("idle_valid", o_valid, 0);

        // beq x0,x0,+16 at 0x100 and squash of the next fetch
        present(32'h0000_0863, 32'h100);
        tick;
        check("beq_valid", o_valid, 1);
        check("beq_taken", o_b_taken, 1);
        check("beq_target", o_b_pc, 32'h110);
        check("beq_rd", o_rd_num, 0);
        present(32'hFFF2_8313, 32'h104);
        #1 check("sq_ready", o_ready, 0);
        tick;
        check("sq_valid", o_valid, 0);
        check("sq_pulse", o_b_taken, 0);

        // Backpressure hold, flush in second stalled cycle
        present(32'hFFF2_8313, 32'h200);
        tick;
        check("hold_load", o_pc, 32'h200);
        i_ex_ready = 1'b0;
        present(32'h0000_A383, 32'h204);
        #1 check("hold_ready", o_ready, 0);
        tick;
        check("hold_valid", o_valid, 1);
        check("hold_pc", o_pc, 32'h200);
        check("hold_rd", o_rd_num, 6);
        check("hold_imm", o_imm, 32'hFFFF_FFFF);
        i_flush = 1'b1;
        #1 check("flush_ready", o_ready, 0);
        tick;
        check("flush_valid", o_valid, 0);
        i_flush = 1'b0;
        tick;
        check("hold3_valid", o_valid, 0);
        check("hold_stall", o_stall_cnt, EXP_STALL);
        i_ex_ready = 1'b1; i_valid = 1'b0;
        tick;

        // Write to x0 is ignored and never bypassed
        i_wb_en = 1'b1; i_wb_rd_num = 5'd0; i_wb_val = 32'hFFFF;
        present(32'h0000_0493, 32'h240);
        tick;
        check("x0_byp", o_rs_1, 0);
        check("x0_rd", o_rd_num, 9);
        i_wb_en = 1'b0;
        present(32'h0003_8513, 32'h244);
        tick;
        check("rf_x7", o_rs_1, 32'hBEEF);
        present(32'h0000_0493, 32'h248);
        tick;
        check("x0_read", o_rs_1, 0);

        // jal x1,+8 at 0x300
        present(32'h0080_00EF, 32'h300);
        tick;
        check("jal_taken", o_b_taken, 1);
        check("jal_target", o_b_pc, 32'h308);
        check("jal_rd", o_rd_num, 1);
        check("jal_imm", o_imm, 8);
        i_valid = 1'b0;
        tick;
        check("jal_pulse", o_b_taken, 0);

        // bne x0,x0 not taken; lui sign bit
        present(32'h0000_1863, 32'h320);
        tick;
        check("bne_valid", o_valid, 1);
        check("bne_taken", o_b_taken, 0);
        present(32'h8000_05B7, 32'h324);
        tick;
        check("lui_imm", o_imm, 32'h8000_0000);
        check("lui_rd", o_rd_num, 11);

        // add x17,x1,x2: legal with 32 registers, illegal with 16
        present(32'h0020_88B3, 32'h328);
        tick;
        check("r32_illegal", o_illegal, 0);
        check("r32_rd", o_rd_num, 17);
        check("r16_valid", e_valid, 1);
        check("r16_illegal", e_illegal, 1);
        check("r16_rd", e_rd_num, 0);
        i_valid = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
